// File: rtl/router_slice_iack_gen_if.sv
// Link-side (4-phase valid/ack) and crossbar-side (valid/ready) signals of the flit receiver.
// With ROUTER_SLICE_IACK_TIMEOUT_EN defined the bundle also carries the sticky err_timeout flag.
interface router_slice_iack_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  iack_d;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [OCC_W-1:0]      occupancy;
`ifdef ROUTER_SLICE_IACK_TIMEOUT_EN
  logic                  err_timeout;
`endif

  // slave = the receiver block, master = the surrounding slice / link model
  modport slave (
    input  in_valid, in_data, out_ready,
    output iack_d, out_valid, out_data, occupancy
`ifdef ROUTER_SLICE_IACK_TIMEOUT_EN
    , output err_timeout
`endif
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  iack_d, out_valid, out_data, occupancy
`ifdef ROUTER_SLICE_IACK_TIMEOUT_EN
    , input err_timeout
`endif
  );
endinterface

// File: rtl/router_slice_iack_gen.sv
// Flit receiver: 4-phase link capture into a DEPTH FIFO; write and ack register on the in_valid-rise edge, a full FIFO withholds the ack.
// Optional ROUTER_SLICE_IACK_TIMEOUT_EN: ACK state abandoned after ACK_TIMEOUT cycles, flagged sticky on err_timeout.
module router_slice_iack_gen #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input logic                     clk,
  input logic                     reset,
  router_slice_iack_gen_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACK_TIMEOUT < 1) begin : g_param_chk
    $error("router_slice_iack_gen: DEPTH must be a power of two >= 2 and ACK_TIMEOUT >= 1");
  end

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t                state_q;
  logic                  iack_q;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  push, pop;

  // Full check uses registered occupancy, so a pop never frees a slot for the same edge.
  assign push = (state_q == IDLE) && bus.in_valid && (occ_q != OCC_W'(DEPTH));
  assign pop  = (occ_q != '0) && bus.out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

`ifdef ROUTER_SLICE_IACK_TIMEOUT_EN
  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(ACK_TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iack_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            state_q <= ACK;
            iack_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ACK: begin
          if (!bus.in_valid) begin
            state_q <= IDLE;
            iack_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            // Sender still holding in_valid when we return to IDLE gets a second write.
            if (cnt_q + CNT_W'(1) == TMO) begin
              state_q <= IDLE;
              iack_q  <= 1'b0;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          iack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.err_timeout = err_q;
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      iack_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (push) begin
            state_q <= ACK;
            iack_q  <= 1'b1;
          end
        end
        ACK: begin
          if (!bus.in_valid) begin
            state_q <= IDLE;
            iack_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          iack_q  <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign bus.iack_d    = iack_q;
  assign bus.out_valid = (occ_q != '0);
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign bus.occupancy = occ_q;
endmodule
